// File: rtl/gcd_issuer.sv
// Initiator for the GCD engine: takes tagged operand pairs, pulses the engine load, and returns tagged results.
// Optional watchdog on the engine wait is compiled in with `define GCD_WDOG_EN.
module gcd_issuer #(
  parameter int XLEN        = 32,
  parameter int TAGW        = 4,
  parameter int WDOG_CYCLES = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [TAGW-1:0] op_tag,
  output logic            ld_o,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o,
  input  logic            done_i,
  input  logic [XLEN-1:0] gcd_i,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_gcd,
  output logic [TAGW-1:0] res_tag,
  output logic            res_err,
  output logic            busy,
  output logic [15:0]     done_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

  state_t state, state_nx;
  logic   accept;
  logic   bypass;
  logic   expire;

  assign op_ready  = (state == IDLE) && !reset;
  assign accept    = op_valid && op_ready;
  // A zero operand makes the GCD trivially the other operand, so the engine is skipped.
  assign bypass    = (op_a == '0) || (op_b == '0);
  assign ld_o      = (state == LOAD);
  assign res_valid = (state == RESP);
  assign busy      = (state != IDLE);

`ifdef GCD_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_cnt;

  assign expire = (wdog_cnt == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt <= '0;
      res_err  <= 1'b0;
    end else begin
      if (state == LOAD)
        wdog_cnt <= '0;
      else if (state == WAIT)
        wdog_cnt <= wdog_cnt + 1'b1;

      if (accept)
        res_err <= 1'b0;
      else if (state == WAIT && !done_i && expire)
        res_err <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = bypass ? RESP : LOAD;
      LOAD: state_nx = WAIT;
      WAIT: if (done_i || expire) state_nx = RESP;
      RESP: if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_o      <= '0;
      b_o      <= '0;
      res_gcd  <= '0;
      res_tag  <= '0;
      done_cnt <= '0;
    end else begin
      if (accept) begin
        a_o     <= op_a;
        b_o     <= op_b;
        res_tag <= op_tag;
        if (bypass) res_gcd <= op_a | op_b;
      end
      // done_i wins over a simultaneous watchdog expiry.
      if (state == WAIT) begin
        if (done_i)      res_gcd <= gcd_i;
        else if (expire) res_gcd <= '0;
      end
      if (state == RESP && res_ready)
        done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule
